// File: rtl/bus_arbit_2m_if.sv
// Request/grant bundle between the two bus masters and the bus_arbit_2m arbiter.
// master = requester side, slave = arbiter side.
interface bus_arbit_2m_if #(
    parameter int unsigned CNT_W = 5
);
    logic             m0_req;
    logic             m1_req;
    logic             m0_grant;
    logic             m1_grant;
    logic             m_sel;
    logic             busy;
    logic [CNT_W-1:0] hold_cnt;

    modport master (
        output m0_req, m1_req,
        input  m0_grant, m1_grant, m_sel, busy, hold_cnt
    );

    modport slave (
        input  m0_req, m1_req,
        output m0_grant, m1_grant, m_sel, busy, hold_cnt
    );
endinterface

// File: rtl/bus_arbit_2m.sv
// Two-master bus arbiter with one-hot registered grants and bounded hold time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaks; otherwise M0 wins every tie.
module bus_arbit_2m #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input logic            clk,
    input logic            reset,
    bus_arbit_2m_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

    localparam bit               HoldEn  = (MAX_HOLD != 0);
    localparam int unsigned      HoldLim = HoldEn ? MAX_HOLD - 1 : 0;
    localparam logic [CNT_W-1:0] HoldLimC = CNT_W'(HoldLim);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             tie_to_m1;

`ifdef ARB_ROUND_ROBIN_EN
    // last_q: 0 = M0 was the last owner, 1 = M1. Reset to M1 so M0 wins the first tie.
    logic last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (state_q == StG0 && state_d != StG0) begin
            last_q <= 1'b0;
        end else if (state_q == StG1 && state_d != StG1) begin
            last_q <= 1'b1;
        end
    end

    assign tie_to_m1 = ~last_q;
`else
    assign tie_to_m1 = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                if (bus.m0_req && bus.m1_req) begin
                    state_d = tie_to_m1 ? StG1 : StG0;
                end else if (bus.m0_req) begin
                    state_d = StG0;
                end else if (bus.m1_req) begin
                    state_d = StG1;
                end
            end
            StG0: begin
                if (!bus.m0_req) begin
                    state_d = bus.m1_req ? StG1 : StIdle;
                end else if (bus.m1_req && HoldEn && cnt_q >= HoldLimC) begin
                    // >= also covers a count that ran past the limit while M1 was quiet
                    state_d = StG1;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StG1: begin
                if (!bus.m1_req) begin
                    state_d = bus.m0_req ? StG0 : StIdle;
                end else if (bus.m0_req && HoldEn && cnt_q >= HoldLimC) begin
                    state_d = StG0;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
        // m_sel keeps its value through IDLE so the address mux does not glitch
        if (state_d == StG0) begin
            sel_d = 1'b0;
        end else if (state_d == StG1) begin
            sel_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.m0_grant = (state_q == StG0);
    assign bus.m1_grant = (state_q == StG1);
    assign bus.busy     = (state_q == StG0) || (state_q == StG1);
    assign bus.m_sel    = sel_q;
    assign bus.hold_cnt = cnt_q;
endmodule

// File: tb/tb_bus_arbit_2m.sv
// Self-checking bench for bus_arbit_2m: three instances (MAX_HOLD 16, 4, 0) share one request
// stream and are each checked every cycle against a behavioural model.
module tb_bus_arbit_2m;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m0_req = 1'b0;
    logic m1_req = 1'b0;

    always #5 clk = ~clk;

    bus_arbit_2m_if #(.CNT_W(5)) bus_a ();
    bus_arbit_2m_if #(.CNT_W(5)) bus_b ();
    bus_arbit_2m_if #(.CNT_W(5)) bus_c ();

    assign bus_a.m0_req = m0_req;
    assign bus_a.m1_req = m1_req;
    assign bus_b.m0_req = m0_req;
    assign bus_b.m1_req = m1_req;
    assign bus_c.m0_req = m0_req;
    assign bus_c.m1_req = m1_req;

    bus_arbit_2m #(.MAX_HOLD(16), .CNT_W(5)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    bus_arbit_2m #(.MAX_HOLD(4),  .CNT_W(5)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    bus_arbit_2m #(.MAX_HOLD(0),  .CNT_W(5)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    logic [2:0]  dg0, dg1, dsel, dbusy;
    logic [14:0] dcnt;
    assign dg0   = {bus_c.m0_grant, bus_b.m0_grant, bus_a.m0_grant};
    assign dg1   = {bus_c.m1_grant, bus_b.m1_grant, bus_a.m1_grant};
    assign dsel  = {bus_c.m_sel,    bus_b.m_sel,    bus_a.m_sel};
    assign dbusy = {bus_c.busy,     bus_b.busy,     bus_a.busy};
    assign dcnt  = {bus_c.hold_cnt, bus_b.hold_cnt, bus_a.hold_cnt};

    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner 0 = nobody, 1 = M0, 2 = M1; held = cycles the owner has held the bus.
    int mh[3] = '{16, 4, 0};
    int owner[3];
    int held[3];
    int last[3];
    int msel[3];

    task automatic check(input string name, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            owner[k] = 0;
            held[k]  = 0;
            last[k]  = 2;
            msel[k]  = 0;
        end
    endtask

    task automatic model_step(input int k, input bit r0, input bit r1);
        int mine;
        int other;
        int nxt;
        if (owner[k] == 0) begin
            nxt = 0;
            if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
                nxt = (last[k] == 1) ? 2 : 1;
`else
                nxt = 1;
`endif
            end else if (r0) begin
                nxt = 1;
            end else if (r1) begin
                nxt = 2;
            end
            owner[k] = nxt;
            held[k]  = 0;
        end else begin
            mine  = (owner[k] == 1) ? int'(r0) : int'(r1);
            other = (owner[k] == 1) ? int'(r1) : int'(r0);
            if (mine == 0 || (other == 1 && mh[k] != 0 && held[k] + 1 >= mh[k])) begin
                last[k]  = owner[k];
                owner[k] = (other == 1) ? 3 - owner[k] : 0;
                held[k]  = 0;
            end else if (held[k] < 31) begin
                held[k]++;
            end
        end
        if (owner[k] != 0) msel[k] = owner[k] - 1;
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check("m0_grant", k, int'(dg0[k]), int'(owner[k] == 1));
            check("m1_grant", k, int'(dg1[k]), int'(owner[k] == 2));
            check("m_sel",    k, int'(dsel[k]), msel[k]);
            check("busy",     k, int'(dbusy[k]), int'(owner[k] != 0));
            check("hold_cnt", k, int'(dcnt[k*5 +: 5]), held[k]);
            check("onehot",   k, int'(dg0[k] & dg1[k]), 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) model_step(k, m0_req, m1_req);
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit r0;
        bit r1;
        bit g0;
        bit g1;
        bit sel;
        int cnt;
    } vec_t;

    vec_t vec[21];

    initial begin
        // Expected outputs of the MAX_HOLD=4 instance after each edge.
        vec[0]  = '{1, 0, 1, 0, 0, 0};
        vec[1]  = '{1, 1, 1, 0, 0, 1};
        vec[2]  = '{1, 1, 1, 0, 0, 2};
        vec[3]  = '{1, 1, 1, 0, 0, 3};
        vec[4]  = '{1, 1, 0, 1, 1, 0};
        vec[5]  = '{1, 1, 0, 1, 1, 1};
        vec[6]  = '{1, 1, 0, 1, 1, 2};
        vec[7]  = '{1, 1, 0, 1, 1, 3};
        vec[8]  = '{1, 1, 1, 0, 0, 0};
        vec[9]  = '{0, 1, 0, 1, 1, 0};
        vec[10] = '{0, 0, 0, 0, 1, 0};
        vec[11] = '{0, 0, 0, 0, 1, 0};
        vec[12] = '{1, 1, 1, 0, 0, 0};
        vec[13] = '{0, 0, 0, 0, 0, 0};
`ifdef ARB_ROUND_ROBIN_EN
        vec[14] = '{1, 1, 0, 1, 1, 0};
`else
        vec[14] = '{1, 1, 1, 0, 0, 0};
`endif
        vec[15] = '{0, 0, 0, 0, vec[14].sel, 0};
        vec[16] = '{0, 1, 0, 1, 1, 0};
        vec[17] = '{0, 1, 0, 1, 1, 1};
        vec[18] = '{0, 1, 0, 1, 1, 2};
        vec[19] = '{0, 1, 0, 1, 1, 3};
        vec[20] = '{0, 0, 0, 0, 1, 0};

        // Reset held with a request pending: everything stays zero.
        model_reset();
        m0_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        foreach (vec[i]) begin
            m0_req = vec[i].r0;
            m1_req = vec[i].r1;
            tick();
            check("vec_g0",  i, int'(bus_b.m0_grant), int'(vec[i].g0));
            check("vec_g1",  i, int'(bus_b.m1_grant), int'(vec[i].g1));
            check("vec_sel", i, int'(bus_b.m_sel), int'(vec[i].sel));
            check("vec_cnt", i, int'(bus_b.hold_cnt), vec[i].cnt);
        end

        // Lone M0 saturates the counter; the unlimited instance then never yields.
        do_reset();
        m0_req = 1'b1;
        repeat (40) tick();
        for (int k = 0; k < 3; k++) check("sat_cnt", k, int'(dcnt[k*5 +: 5]), 31);
        m1_req = 1'b1;
        repeat (10) begin
            tick();
            check("nohold_g1", 2, int'(bus_c.m1_grant), 0);
            check("nohold_cnt", 2, int'(bus_c.hold_cnt), 31);
        end

        // Asynchronous reset in the middle of an M1 grant.
        do_reset();
        m1_req = 1'b1;
        repeat (3) tick();
        check("pre_rst_g1", 1, int'(bus_b.m1_grant), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check("rst_g1",   k, int'(dg1[k]), 0);
            check("rst_busy", k, int'(dbusy[k]), 0);
            check("rst_cnt",  k, int'(dcnt[k*5 +: 5]), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Random request traffic; requests toggle rarely so grants get held.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) m0_req = ~m0_req;
            if ($urandom_range(3) == 0) m1_req = ~m1_req;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
